// File: rtl/udp_tx_pkg.sv
// udp_tx_pkg: shared definitions for the UDP TX buffer arbiter.
//   - buffer word indices of the header and payload region
//   - FSM state encoding
//   - latched header record and its word-view helper
package udp_tx_pkg;

    localparam int TXBUF_AW = 9;

    localparam int W_DST_IP = 0;
    localparam int W_PORTS  = 1;
    localparam int W_LEN    = 2;
    localparam int W_PLD    = 3;

    localparam int IP_W   = 32;
    localparam int PORT_W = 16;
    localparam int LEN_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REL   = 2'd1,
        S_WDROP = 2'd2,
        S_WRET  = 2'd3
    } state_e;

    typedef struct packed {
        logic [IP_W-1:0]   dst_ip;
        logic [PORT_W-1:0] src_port;
        logic [PORT_W-1:0] dst_port;
        logic [LEN_W-1:0]  len;
    } hdr_t;

    // Header word as seen by ros2_ether at buffer word index w (w < W_PLD).
    function automatic logic [31:0] hdr_word(hdr_t h, logic [1:0] w);
        logic [31:0] r;
        r = '0;
        case (w)
            2'(W_DST_IP): r = h.dst_ip;
            2'(W_PORTS):  r = {h.src_port, h.dst_port};
            2'(W_LEN):    r = {16'h0000, h.len};
            default:      r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    : request vector
//   ptr    : index holding highest priority this round
//   valid  : some request is present
//   onehot : winner as one-hot
//   idx    : winner index (first requester at or after ptr, wrapping)
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);

    always_comb begin
        valid  = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (int'(ptr) + i) % N;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end
endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: shares ros2_ether's single UDP TX buffer port among NUM_CLI
// local senders. Runs the grant/rel handshake, picks a winner round-robin,
// serves the 3 header words from registers latched at acceptance and forwards
// payload reads (word 3 onward) to the winner's payload memory.
// Ports:
//   clk_int, rst_n            clock, async active-low reset
//   cli_req/dst_ip/src_port/dst_port/len   per-client request and header
//   cli_ack/done/err          per-client 1-cycle status pulses
//   pld_addr, pld_ce, pld_rdata             payload memory read port
//   udp_txbuf_*               ros2_ether buffer port
module udp_tx_arbiter
    import udp_tx_pkg::*;
#(
    parameter int NUM_CLI = 4,
    parameter int MAX_PLD = 60,
    parameter int RD_LAT  = 0,
    parameter int TIMEOUT = 125000000,
    parameter int AW      = TXBUF_AW
) (
    input  logic                     clk_int,
    input  logic                     rst_n,
    input  logic [NUM_CLI-1:0]       cli_req,
    input  logic [NUM_CLI-1:0][31:0] cli_dst_ip,
    input  logic [NUM_CLI-1:0][15:0] cli_src_port,
    input  logic [NUM_CLI-1:0][15:0] cli_dst_port,
    input  logic [NUM_CLI-1:0][15:0] cli_len,
    output logic [NUM_CLI-1:0]       cli_ack,
    output logic [NUM_CLI-1:0]       cli_done,
    output logic [NUM_CLI-1:0]       cli_err,
    output logic [AW-1:0]            pld_addr,
    output logic [NUM_CLI-1:0]       pld_ce,
    input  logic [NUM_CLI-1:0][31:0] pld_rdata,
    input  logic                     udp_txbuf_grant,
    output logic                     udp_txbuf_rel,
    input  logic [AW-1:0]            udp_txbuf_addr,
    input  logic                     udp_txbuf_ce,
    output logic [31:0]              udp_txbuf_rdata
);
    localparam int IW = $clog2(NUM_CLI);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PLD);

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   win_q, win_d;
    hdr_t            hdr_q, hdr_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            run_q, run_d;

    logic               pick_vld;
    logic [NUM_CLI-1:0] pick_oh;
    logic [IW-1:0]      pick_idx;
    logic [NUM_CLI-1:0] win_oh;
    logic               go, too_long, in_wait, tmo_hit, locked, addr_pld;
    logic [31:0]        hdr_rd;

    rr_pick #(.N(NUM_CLI)) u_pick (
        .req    (cli_req),
        .ptr    (rr_q),
        .valid  (pick_vld),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    // run_q keeps the IDLE decision (and its comb pulses) quiet while reset is held.
    assign run_d    = 1'b1;
    assign go       = run_q && udp_txbuf_grant && pick_vld;
    assign too_long = cli_len[pick_idx] > MAX_LEN;
    assign in_wait  = (state_q == S_WDROP) || (state_q == S_WRET);
    assign tmo_hit  = in_wait && (tmo_q == TW'(TIMEOUT - 1));
    assign win_oh   = NUM_CLI'(1) << win_q;
    // Counter restarts on every state entry and only runs while waiting on grant.
    assign tmo_d    = (in_wait && state_d == state_q) ? tmo_q + 1'b1 : '0;

    // State register
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            hdr_q   <= '0;
            tmo_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            hdr_q   <= hdr_d;
            tmo_q   <= tmo_d;
            run_q   <= run_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        hdr_d   = hdr_q;
        case (state_q)
            S_IDLE: if (go) begin
                if (too_long) begin
                    // Skip the oversize requester so the others are not starved by it.
                    rr_d = (pick_idx == IW'(NUM_CLI - 1)) ? '0 : pick_idx + 1'b1;
                end else begin
                    win_d   = pick_idx;
                    hdr_d   = '{dst_ip:   cli_dst_ip[pick_idx],
                                src_port: cli_src_port[pick_idx],
                                dst_port: cli_dst_port[pick_idx],
                                len:      cli_len[pick_idx]};
                    state_d = S_REL;
                end
            end
            S_REL: begin
                rr_d    = (win_q == IW'(NUM_CLI - 1)) ? '0 : win_q + 1'b1;
                state_d = S_WDROP;
            end
            S_WDROP: if (tmo_hit || !udp_txbuf_grant) state_d = tmo_hit ? S_IDLE : S_WRET;
            S_WRET:  if (tmo_hit || udp_txbuf_grant)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cli_ack       = '0;
        cli_done      = '0;
        cli_err       = '0;
        udp_txbuf_rel = 1'b0;
        case (state_q)
            S_IDLE: if (go) begin
                if (too_long) cli_err = pick_oh;
                else          cli_ack = pick_oh;
            end
            S_REL:   udp_txbuf_rel = 1'b1;
            S_WDROP: if (tmo_hit) cli_err = win_oh;
            S_WRET: begin
                if (tmo_hit)              cli_err  = win_oh;
                else if (udp_txbuf_grant) cli_done = win_oh;
            end
            default: ;
        endcase
    end

    // Read path: the mux is locked to win_q for the whole time ros2_ether owns the buffer.
    assign locked   = (state_q != S_IDLE);
    assign addr_pld = (udp_txbuf_addr >= AW'(W_PLD));
    assign pld_addr = addr_pld ? udp_txbuf_addr - AW'(W_PLD) : '0;
    assign pld_ce   = (locked && udp_txbuf_ce && addr_pld) ? win_oh : '0;
    assign hdr_rd   = hdr_word(hdr_q, udp_txbuf_addr[1:0]);

    generate
        if (RD_LAT == 0) begin : g_rd_comb
            always_comb begin
                udp_txbuf_rdata = hdr_rd;
                if (addr_pld) udp_txbuf_rdata = locked ? pld_rdata[win_q] : '0;
            end
        end else begin : g_rd_reg
            // Header word and path select are captured on ce so they line up with
            // the registered output of the client payload memories.
            logic [31:0] rd_hdr_q, rd_hdr_d;
            logic        rd_pld_q, rd_pld_d;

            always_comb begin
                rd_hdr_d = rd_hdr_q;
                rd_pld_d = rd_pld_q;
                if (udp_txbuf_ce) begin
                    rd_hdr_d = addr_pld ? '0 : hdr_rd;
                    rd_pld_d = addr_pld && locked;
                end
            end

            always_ff @(posedge clk_int or negedge rst_n) begin
                if (!rst_n) begin
                    rd_hdr_q <= '0;
                    rd_pld_q <= 1'b0;
                end else begin
                    rd_hdr_q <= rd_hdr_d;
                    rd_pld_q <= rd_pld_d;
                end
            end

            assign udp_txbuf_rdata = rd_pld_q ? pld_rdata[win_q] : rd_hdr_q;
        end
    endgenerate
endmodule

// File: tb/tb_udp_tx_arbiter.sv
module tb_udp_tx_arbiter;
    localparam int N    = 4;
    localparam int MAXP = 60;
    localparam int TMO  = 100;
    localparam int AW   = 9;

    logic                 clk_int = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         cli_req;
    logic [N-1:0][31:0]   cli_dst_ip;
    logic [N-1:0][15:0]   cli_src_port, cli_dst_port, cli_len;
    logic [N-1:0]         cli_ack, cli_done, cli_err, pld_ce;
    logic [AW-1:0]        pld_addr, txaddr;
    logic [N-1:0][31:0]   pld_rdata;
    logic                 grant, rel, ce;
    logic [31:0]          rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int rr    = 0;        // model: client with highest priority next
    int mseed = 0;        // payload memory content seed
    logic [N-1:0] hold = '0;  // clients that keep req asserted after being served

    always #5 clk_int = ~clk_int;

    udp_tx_arbiter #(.NUM_CLI(N), .MAX_PLD(MAXP), .RD_LAT(1), .TIMEOUT(TMO), .AW(AW)) dut (
        .clk_int(clk_int), .rst_n(rst_n), .cli_req(cli_req), .cli_dst_ip(cli_dst_ip),
        .cli_src_port(cli_src_port), .cli_dst_port(cli_dst_port), .cli_len(cli_len),
        .cli_ack(cli_ack), .cli_done(cli_done), .cli_err(cli_err), .pld_addr(pld_addr),
        .pld_ce(pld_ce), .pld_rdata(pld_rdata), .udp_txbuf_grant(grant), .udp_txbuf_rel(rel),
        .udp_txbuf_addr(txaddr), .udp_txbuf_ce(ce), .udp_txbuf_rdata(rdata)
    );

    function automatic logic [31:0] memv(int c, int k, int s);
        return (32'(c) * 32'h01000193) ^ (32'(k) * 32'h9e3779b9) ^ 32'(s);
    endfunction

    // Client payload memories, one cycle read latency.
    always @(posedge clk_int)
        for (int c = 0; c < N; c++)
            if (pld_ce[c]) pld_rdata[c] <= memv(c, int'(pld_addr), mseed);

    function automatic logic [N-1:0] oh(int c);
        logic [N-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Round-robin reference: first requester at or after rr, wrapping.
    function automatic int pick(logic [N-1:0] r);
        for (int i = 0; i < N; i++)
            if (r[(rr + i) % N]) return (rr + i) % N;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk_int);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ack"}, cli_ack, 0);
        chk({tag, "_done"}, cli_done, 0);
        chk({tag, "_err"}, cli_err, 0);
        chk({tag, "_rel"}, rel, 0);
        chk({tag, "_ce"}, pld_ce, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    // One arbitration from IDLE with grant high. Ends at the sample point of the
    // first cycle back in IDLE.
    task automatic txn(input bit tmo_mode);
        int w, nw;
        logic [31:0] hw [3];
        #1;
        w = pick(cli_req);
        if (w < 0) begin
            chk("ack_none", cli_ack, 0);
            nx();
            return;
        end
        if (int'(cli_len[w]) > MAXP) begin
            chk("rej_err", cli_err, oh(w));
            chk("rej_ack", cli_ack, 0);
            rr = (w + 1) % N;
            nx();
            chk("rej_rel", rel, 0);
            cli_req[w] = 1'b0;
            #1;
            return;
        end
        chk("ack", cli_ack, oh(w));
        chk("ack_err", cli_err, 0);
        hw[0] = cli_dst_ip[w];
        hw[1] = {cli_src_port[w], cli_dst_port[w]};
        hw[2] = {16'h0000, cli_len[w]};
        nw    = 3 + (int'(cli_len[w]) + 3) / 4;
        nx();
        if (!hold[w]) cli_req[w] = 1'b0;
        chk("rel", rel, 1);
        chk("rel_ack", cli_ack, 0);
        rr = (w + 1) % N;
        if (tmo_mode) begin
            // grant never drops: abort after TMO cycles in WDROP
            for (int t = 1; t <= TMO; t++) begin
                nx();
                if (t < TMO) chk("tmo_early", cli_err, 0);
                else         chk("tmo_err", cli_err, oh(w));
                chk("tmo_done", cli_done, 0);
            end
            nx();
            chk("tmo_after", cli_err, 0);
            return;
        end
        grant = 1'b0;
        nx();
        chk("rel_once", rel, 0);
        nx();
        for (int k = 0; k < nw; k++) begin
            txaddr = AW'(k);
            ce     = 1'b1;
            #1;
            if (k >= 3) chk("pld_ce", pld_ce, oh(w));
            else        chk("hdr_ce", pld_ce, 0);
            nx();
            ce = 1'b0;
            if (k < 3) chk("hdr_word", rdata, hw[k]);
            else       chk("pld_word", rdata, memv(w, k - 3, mseed));
        end
        grant = 1'b1;
        #1;
        chk("done", cli_done, oh(w));
        chk("done_err", cli_err, 0);
        nx();
        chk("done_once", cli_done, 0);
    endtask

    task automatic rand_cli(input int c, input int lmax);
        cli_dst_ip[c]   = $urandom;
        cli_src_port[c] = 16'($urandom);
        cli_dst_port[c] = 16'($urandom);
        cli_len[c]      = 16'($urandom_range(0, lmax));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cli_req = '0; grant = 1'b1; ce = 1'b0; txaddr = '0;
        cli_dst_ip = '0; cli_src_port = '0; cli_dst_port = '0; cli_len = '0;
        for (int c = 0; c < N; c++) rand_cli(c, MAXP);

        // Reset: request and grant present, nothing may leak out.
        cli_req = 4'b0001;
        repeat (3) nx();
        chk_quiet("reset");
        chk("reset_paddr", pld_addr, 0);
        cli_req = '0;

        // Single client 2 with known header; grant already high at release.
        cli_dst_ip[2] = {8'd10, 8'd1, 8'd168, 8'd192};
        cli_src_port[2] = 16'd1111; cli_dst_port[2] = 16'd1234; cli_len[2] = 16'd15;
        rst_n = 1'b1;
        nx();
        cli_req = 4'b0100;
        txn(0);

        // Reset while in WRET, request still held: fresh start with a single ack.
        rand_cli(3, MAXP);
        cli_req = 4'b1000;
        #1;
        chk("mid_ack", cli_ack, oh(pick(cli_req)));
        nx();
        chk("mid_rel", rel, 1);
        grant = 1'b0;
        nx(); nx();
        txaddr = AW'(4); ce = 1'b1;
        #1;
        chk("mid_ce", pld_ce, oh(3));
        rst_n = 1'b0;
        #1;
        chk_quiet("mid_rst");
        grant = 1'b1; ce = 1'b0; txaddr = '0; rr = 0;
        nx();
        rst_n = 1'b1;
        nx();
        txn(0);

        // Clients 0,1,3 together, 0 keeps requesting: order 0,1,3,0.
        for (int c = 0; c < N; c++) rand_cli(c, MAXP);
        cli_req = 4'b1011; hold = 4'b0001;
        txn(0); txn(0); txn(0);
        hold = '0;
        txn(0);

        // Oversize client 1 rejected, pending client 2 served next cycle.
        rand_cli(1, MAXP); rand_cli(2, MAXP);
        cli_len[1] = 16'(MAXP + 1);
        cli_req = 4'b0110;
        txn(0);
        txn(0);

        // Grant never returns.
        rand_cli(0, MAXP);
        cli_req = 4'b0001;
        txn(1);

        // Randomized request sets, including oversize and zero lengths.
        for (int it = 0; it < 25; it++) begin
            mseed = int'($urandom);
            for (int c = 0; c < N; c++) rand_cli(c, MAXP + 6);
            if (it % 5 == 0) cli_len[it % N] = 16'd0;
            cli_req = 4'($urandom_range(1, 15));
            for (int g = 0; g < N && cli_req != '0; g++) txn(0);
            chk("rand_drain", cli_req, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
